// File: rtl/pixel_pkg.sv
// Shared screen geometry, pixel layout and bounds helper for the pixel path.
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int PIX_W    = X_W + Y_W + COLOUR_W;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  // True when the pixel lies inside the configured visible window.
  function automatic logic on_screen(pixel_t p, int x_max, int y_max);
    return (32'(p.x) <= 32'(x_max)) && (32'(p.y) <= 32'(y_max));
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Circular pixel buffer; pointers wrap naturally because DEPTH is a power of two.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  pixel_t        din,
  input  logic          pop,
  output pixel_t        dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array carries no reset; empty-state masking happens downstream.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; a simultaneous push/pop keeps level steady.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_arbiter.sv
// Two-source round-robin pixel arbiter feeding a FIFO toward the VGA adapter;
// off-screen pixels are consumed but discarded and counted.
module pixel_arbiter
  import pixel_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int X_MAX = SCREEN_W - 1,
  parameter  int Y_MAX = SCREEN_H - 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                s0_valid,
  input  logic [X_W-1:0]      s0_x,
  input  logic [Y_W-1:0]      s0_y,
  input  logic [COLOUR_W-1:0] s0_colour,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic [X_W-1:0]      s1_x,
  input  logic [Y_W-1:0]      s1_y,
  input  logic [COLOUR_W-1:0] s1_colour,
  output logic                s1_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  input  logic                out_ready,
  output logic [LW-1:0]       level,
  output logic [7:0]          dropped
);

  src_e    last_grant;
  src_e    gnt;
  logic    gnt_vld;
  logic    full;
  logic    empty;
  logic    xfer;
  logic    keep;
  pixel_t  acc_pix;
  pixel_t  head;

  // Grant: lone requester wins; on a tie the source not served last wins.
  always_comb begin
    gnt_vld = s0_valid || s1_valid;
    gnt     = SRC0;
    if (s0_valid && s1_valid)
      gnt = (last_grant == SRC1) ? SRC0 : SRC1;
    else if (s1_valid)
      gnt = SRC1;
  end

  // No full pass-through: a full FIFO blocks both sources even during a pop.
  assign s0_ready = gnt_vld && (gnt == SRC0) && !full;
  assign s1_ready = gnt_vld && (gnt == SRC1) && !full;
  assign xfer     = (s0_valid && s0_ready) || (s1_valid && s1_ready);

  assign acc_pix  = (gnt == SRC1) ? pixel_t'{s1_x, s1_y, s1_colour}
                                  : pixel_t'{s0_x, s0_y, s0_colour};
  assign keep     = on_screen(acc_pix, X_MAX, Y_MAX);

  // Round-robin history moves only when a source transfer completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  last_grant <= SRC1;
    else if (xfer) last_grant <= gnt;
  end

  // Saturating count of accepted pixels that fell outside the screen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      dropped <= '0;
    else if (xfer && !keep && dropped != 8'hFF)
      dropped <= dropped + 8'd1;
  end

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (xfer && keep),
    .din     (acc_pix),
    .pop     (writeEn && out_ready),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign writeEn = !empty;
  assign x       = writeEn ? head.x      : '0;
  assign y       = writeEn ? head.y      : '0;
  assign colour  = writeEn ? head.colour : '0;

endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the pixel FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter X_MAX, default 159, meaning the largest on-screen x coordinate.
REQ-003 The block SHALL have parameter Y_MAX, default 119, meaning the largest on-screen y coordinate.
REQ-004 clock  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s0_valid, s1_valid  input  1 each  source 0/1 offers a pixel.
REQ-007 s0_x, s1_x  input  8 each  source pixel x.
REQ-008 s0_y, s1_y  input  7 each  source pixel y.
REQ-009 s0_colour, s1_colour  input  3 each  source pixel colour.
REQ-010 s0_ready, s1_ready  output  1 each  the offered pixel is consumed this cycle.
REQ-011 x  output  8  head-of-FIFO x to the VGA adapter.
REQ-012 y  output  7  head-of-FIFO y.
REQ-013 colour  output  3  head-of-FIFO colour.
REQ-014 writeEn  output  1  a valid pixel is on x/y/colour.
REQ-015 out_ready  input  1  the VGA adapter accepts the pixel this cycle.
REQ-016 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 dropped  output  8  saturating count of off-screen pixels discarded.

Function
REQ-018 A transfer SHALL occur on source i when si_valid and si_ready are both high at a clock edge; at most one source transfer SHALL occur per cycle.
REQ-019 Grant: only one valid source, or both valid -> the source not granted most recently (last_grant register); no valid source -> no grant, last_grant unchanged.
REQ-020 si_ready SHALL equal (grant==i) and (level<DEPTH); si_ready MAY depend combinationally on s0_valid/s1_valid.
REQ-021 last_grant SHALL update only on a completed source transfer.
REQ-022 An accepted pixel with x>X_MAX or y>Y_MAX SHALL NOT be written to the FIFO and SHALL increment dropped, saturating at 255.
REQ-023 An accepted on-screen pixel SHALL be written to the FIFO tail; with an empty FIFO it SHALL appear on x/y/colour with writeEn high in the next cycle (1-cycle latency).
REQ-024 writeEn SHALL equal (level!=0); x/y/colour SHALL be 0 when level==0.
REQ-025 The head entry SHALL be popped at an edge where writeEn and out_ready are both high.
REQ-026 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-027 At level==DEPTH both si_ready SHALL be low, even if a pop occurs in the same cycle (no full pass-through).
REQ-028 Pixel order at the output SHALL equal acceptance order; read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 On reset_n low, level, pointers and dropped SHALL clear to 0 immediately, last_grant SHALL be set to 1 (source 0 wins the first tie), and writeEn, x, y and colour SHALL read 0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered pixels; no pixel SHALL be emitted in the first cycle after release.

Structure
REQ-031 Screen limits (160x120), coordinate widths (8/7) and colour width (3) SHALL live in shared package pixel_pkg.
REQ-032 Storage SHALL be one sub-module pixel_fifo (push/pop/full/empty/level, DEPTH-parameterised); arbitration, bounds check and drop counter stay in pixel_arbiter.

Verification
REQ-033 Reset, s0 offers (10,20,3'b100), out_ready=1 -> s0_ready=1; next cycle writeEn=1, x=10, y=20, colour=4; following cycle writeEn=0.
REQ-034 Both sources valid every cycle, out_ready=1 -> grants alternate s0,s1,s0,s1, first grant s0.
REQ-035 out_ready=0, s0 pushes 5 pixels -> 4 accepted, level=4, s0_ready=0 on the 5th; raise out_ready -> 4 pixels emitted in order, then the 5th.
REQ-036 s1 offers (160,0) then (0,120) then (5,5) -> both off-screen pixels accepted and dropped, dropped=2, only (5,5) emitted.
REQ-037 level=3, reset_n pulsed low asynchronously -> level=0 and writeEn=0 before the next edge; no stale pixel after release.
REQ-038 300 off-screen pixels -> dropped saturates at 255.
